// File: rtl/eight_to_three_enc_stream.sv
// Streams the 3-bit index of every set bit of an 8-bit request vector, one code
// per valid/ready handshake, in LSB-first or MSB-first priority order.
module eight_to_three_enc_stream #(
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit EMIT_EMPTY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic       out_none,
  output logic [3:0] out_count,
  output logic [1:0] dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; once raised, out_valid and its payload hold until that transfer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_pending;
  logic [3:0] r_count;

  logic [2:0] w_code;
  logic [7:0] w_clear;
  logic       w_one_left;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // The last match in scan order wins, so scan from the low-priority end.
  always_comb begin
    w_code = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) if (r_pending[i]) w_code = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (r_pending[i]) w_code = 3'(i);
    end
  end

  assign w_clear    = 8'd1 << w_code;
  assign w_one_left = (r_pending != 8'd0) && ((r_pending & (r_pending - 8'd1)) == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= 8'd0;
      r_count   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (in_vec != 8'd0) begin
              r_pending <= in_vec;
              r_count   <= popcount(in_vec);
              r_state   <= DRAIN;
            end else if (EMIT_EMPTY) begin
              r_pending <= 8'd0;
              r_count   <= 4'd0;
              r_state   <= EMPTY;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            r_pending <= r_pending & ~w_clear;
            if (w_one_left) r_state <= IDLE;
          end
        end
        EMPTY: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decode of registered state, so nothing on in_* reaches out_*.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DRAIN) || (r_state == EMPTY);
  assign out_code  = (r_state == DRAIN) ? w_code : 3'd0;
  assign out_last  = (r_state == EMPTY) || ((r_state == DRAIN) && w_one_left);
  assign out_none  = (r_state == EMPTY);
  assign out_count = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_eight_to_three_enc_stream.sv
// Directed bench: an LSB-first/EMIT_EMPTY instance and an MSB-first/drop-empty
// instance share clock, reset, in_vec and out_ready.
module tb_eight_to_three_enc_stream;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_vec;
  logic       out_ready;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_last, a_out_none;
  logic [2:0] a_out_code;
  logic [3:0] a_out_count;
  logic [1:0] a_dbg_state;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_none;
  logic [2:0] b_out_code;
  logic [3:0] b_out_count;
  logic [1:0] b_dbg_state;

  int n_vec;
  int n_fail;

  logic [2:0] exp_q[$];

  // Selected-instance view used by the drain task.
  bit         sel;
  logic       s_in_ready, s_out_valid, s_out_last, s_out_none;
  logic [2:0] s_out_code;
  logic [3:0] s_out_count;

  always_comb begin
    s_in_ready  = sel ? b_in_ready  : a_in_ready;
    s_out_valid = sel ? b_out_valid : a_out_valid;
    s_out_last  = sel ? b_out_last  : a_out_last;
    s_out_none  = sel ? b_out_none  : a_out_none;
    s_out_code  = sel ? b_out_code  : a_out_code;
    s_out_count = sel ? b_out_count : a_out_count;
  end

  eight_to_three_enc_stream #(.LSB_FIRST(1'b1), .EMIT_EMPTY(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(in_vec),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_code(a_out_code),
    .out_last(a_out_last), .out_none(a_out_none), .out_count(a_out_count),
    .dbg_state(a_dbg_state)
  );

  eight_to_three_enc_stream #(.LSB_FIRST(1'b0), .EMIT_EMPTY(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(in_vec),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_code(b_out_code),
    .out_last(b_out_last), .out_none(b_out_none), .out_count(b_out_count),
    .dbg_state(b_dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one vector to the selected instance for exactly one edge.
  task automatic accept(input bit which, input logic [7:0] vec);
    sel = which;
    check("in_ready_before_accept", 32'(s_in_ready), 32'd1);
    in_vec = vec;
    if (which) b_in_valid = 1'b1; else a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    in_vec = 8'($urandom_range(0, 255));
  endtask

  // Drain exp_q from the selected instance; stall_mode 1 gives out_ready 1,0,0,1,0,0...
  task automatic drain(input logic [3:0] cnt, input int stall_mode);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      out_ready = (stall_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      check("out_valid_drain", 32'(s_out_valid), 32'd1);
      check("out_code",        32'(s_out_code),  32'(exp_q[0]));
      check("out_last",        32'(s_out_last),  32'(exp_q.size() == 1));
      check("out_none_drain",  32'(s_out_none),  32'd0);
      check("out_count_drain", 32'(s_out_count), 32'(cnt));
      check("in_ready_drain",  32'(s_in_ready),  32'd0);
      step();
      if (out_ready) void'(exp_q.pop_front());
      cyc++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    out_ready = 1'b0;
    check("in_ready_after", 32'(s_in_ready),  32'd1);
    check("out_valid_after", 32'(s_out_valid), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    in_vec = 8'h00;
    out_ready = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_code",  32'(a_out_code),  32'd0);
    check("rst_out_last",  32'(a_out_last),  32'd0);
    check("rst_out_none",  32'(a_out_none),  32'd0);
    check("rst_out_count", 32'(a_out_count), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(a_in_ready), 32'd1);

    // Empty vector with EMIT_EMPTY=1: one none beat, held while stalled
    accept(1'b0, 8'h00);
    check("empty_valid", 32'(a_out_valid), 32'd1);
    check("empty_none",  32'(a_out_none),  32'd1);
    check("empty_last",  32'(a_out_last),  32'd1);
    check("empty_code",  32'(a_out_code),  32'd0);
    check("empty_count", 32'(a_out_count), 32'd0);
    check("empty_in_ready", 32'(a_in_ready), 32'd0);
    step();
    check("empty_hold_valid", 32'(a_out_valid), 32'd1);
    check("empty_hold_none",  32'(a_out_none),  32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("empty_done_valid", 32'(a_out_valid), 32'd0);
    check("empty_done_ready", 32'(a_in_ready),  32'd1);

    // Empty vector with EMIT_EMPTY=0: silently dropped
    accept(1'b1, 8'h00);
    check("drop_valid", 32'(b_out_valid), 32'd0);
    check("drop_ready", 32'(b_in_ready),  32'd1);

    // 1010_0101 LSB first
    accept(1'b0, 8'hA5);
    exp_q = '{3'd0, 3'd2, 3'd5, 3'd7};
    drain(4'd4, 0);

    // 1010_0101 MSB first
    accept(1'b1, 8'hA5);
    exp_q = '{3'd7, 3'd5, 3'd2, 3'd0};
    drain(4'd4, 0);

    // All ones with stalls
    accept(1'b0, 8'hFF);
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    drain(4'd8, 1);

    // One-hot sweep, the decoder's outputs looped back
    for (int i = 0; i < 8; i++) begin
      accept(1'b0, 8'd1 << i);
      exp_q.push_back(3'(i));
      drain(4'd1, 0);
    end

    // MSB-first single bit at the top and bottom boundaries
    accept(1'b1, 8'h80);
    exp_q = '{3'd7};
    drain(4'd1, 0);
    accept(1'b1, 8'h01);
    exp_q = '{3'd0};
    drain(4'd1, 0);

    // Reset mid-drain discards pending bits
    accept(1'b0, 8'hF0);
    check("f0_first_code", 32'(a_out_code), 32'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("f0_second_code", 32'(a_out_code),  32'd5);
    check("f0_count",       32'(a_out_count), 32'd4);
    step();
    check("f0_stall_code",  32'(a_out_code),  32'd5);
    rst_n = 1'b0;
    step();
    check("midrst_valid", 32'(a_out_valid), 32'd0);
    check("midrst_count", 32'(a_out_count), 32'd0);
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(a_in_ready), 32'd1);
    step();
    accept(1'b0, 8'h02);
    exp_q = '{3'd1};
    drain(4'd1, 0);
    step();
    check("no_leftover_valid", 32'(a_out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
